bf16_fma_add_stage: RTL and testbench

//  Pipelined BF16 adder forming the accumulate half of the FMA datapath: R = P + C.
//  P is the BF16 product from the BF16 multiplier stage, sampled together with its flags.
//  C is the addend. Three register stages with valid/ready on both sides feed the FMA result port.

---
 rtl/bf16_pkg.sv | 55 +++++
 rtl/bf16_lzc.sv | 17 +
 rtl/bf16_fma_add_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_bf16_fma_add_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared types and constants for the BF16 add stage of the FMA datapath.
package bf16_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 7;
    localparam int unsigned BIAS  = 127;
    // Aligned significand: hidden + mantissa + guard + round + sticky
    localparam int unsigned SIG_W = MAN_W + 4;

    localparam logic [15:0] QNAN = 16'h7FC0;
    localparam logic [15:0] PINF = 16'h7F80;

    // Operand class, and also the special-result code carried down the pipe
    typedef enum logic [1:0] {
        ClsNorm,
        ClsZero,
        ClsInf,
        ClsNan
    } spc_cls_e;

    // S1 -> S2: operands swapped so |X| >= |Y|, Y already aligned to X
    typedef struct packed {
        logic             sign_x;
        logic             sign_y;
        logic [EXP_W-1:0] exp_x;
        logic [SIG_W-1:0] sig_x;
        logic [SIG_W-1:0] sig_y;
        spc_cls_e         spc;
        logic             spc_sign;
        logic             p_ovf;
        logic             p_unf;
    } s1_t;

    // S2 -> S3: raw sum with carry-out bit on top
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W:0]   sum;
        spc_cls_e         spc;
        logic             spc_sign;
        logic             p_ovf;
        logic             p_unf;
    } s2_t;

    // Flush-to-zero classification of a BF16 value
    function automatic spc_cls_e classify(input logic [15:0] v);
        if (v[14:7] == 8'hFF) begin
            return (v[6:0] != 7'h0) ? ClsNan : ClsInf;
        end else if (v[14:7] == 8'h00) begin
            return ClsZero;
        end
        return ClsNorm;
    endfunction

endpackage

// File: rtl/bf16_lzc.sv
// 11-bit combinational leading-zero counter used by the normalise stage.
module bf16_lzc (
    input  logic [10:0] din_i,
    output logic [3:0]  cnt_o
);

    // Ascending scan: the highest set bit is the last one to write the count
    always_comb begin
        cnt_o = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (din_i[i]) begin
                cnt_o = 4'(10 - i);
            end
        end
    end

endmodule

// File: rtl/bf16_fma_add_stage.sv
// Three-stage pipelined BF16 adder (R = P + C), accumulate half of the FMA.
// Stages: S1 unpack/classify/align, S2 add/subtract, S3 normalise/round/pack.
// Optional build macro: BF16_ADD_STICKY_FLAGS_EN adds the sticky_flags port.
module bf16_fma_add_stage
    import bf16_pkg::*;
#(
    parameter int unsigned RND_MODE = 0,
    parameter int unsigned FTZ      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] prod,
    input  logic        prod_ovf,
    input  logic        prod_unf,
    input  logic [15:0] addend,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        res_zero,
    output logic        res_ovf,
    output logic        res_unf,
    output logic        res_inv,
    output logic        res_inex
`ifdef BF16_ADD_STICKY_FLAGS_EN
    ,
    output logic [4:0]  sticky_flags
`endif
);

    if (FTZ != 1) begin : gen_ftz_check
        $error("bf16_fma_add_stage: only FTZ = 1 is supported");
    end

    logic       advance;
    logic       v1_q, v2_q, out_valid_q;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    logic [15:0] res_d, res_q;
    logic [4:0] flg_d, flg_q;  // {inex, inv, unf, ovf, zero}

    // Whole pipe moves as one; only a full, blocked output stage stalls it
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // ---------------- S1: classify, swap, align ----------------
    logic [14:0]     mag_p, mag_c, mag_x, mag_y;
    logic            swap;
    logic [7:0]      d;
    logic [3:0]      sh;
    logic [SIG_W-1:0] sig_y_raw;
    logic [2*SIG_W-1:0] ext;
    spc_cls_e        cls_p, cls_c;

    // Flushed magnitudes, swap, and right-shift of Y with sticky collection
    always_comb begin
        cls_p     = classify(prod);
        cls_c     = classify(addend);
        mag_p     = (prod[14:7] == 8'h0) ? 15'h0 : prod[14:0];
        mag_c     = (addend[14:7] == 8'h0) ? 15'h0 : addend[14:0];
        swap      = mag_c > mag_p;
        mag_x     = swap ? mag_c : mag_p;
        mag_y     = swap ? mag_p : mag_c;
        d         = mag_x[14:7] - mag_y[14:7];
        sh        = (d > 8'd11) ? 4'd11 : d[3:0];
        sig_y_raw = (mag_y[14:7] == 8'h0) ? '0 : {1'b1, mag_y[6:0], 3'b000};
        ext       = {sig_y_raw, {SIG_W{1'b0}}} >> sh;

        s1_d.sign_x = swap ? addend[15] : prod[15];
        s1_d.sign_y = swap ? prod[15] : addend[15];
        s1_d.exp_x  = mag_x[14:7];
        s1_d.sig_x  = (mag_x[14:7] == 8'h0) ? '0 : {1'b1, mag_x[6:0], 3'b000};
        s1_d.sig_y  = {ext[21:12], ext[11] | (|ext[10:0])};
        s1_d.p_ovf  = prod_ovf;
        s1_d.p_unf  = prod_unf;

        s1_d.spc      = ClsNorm;
        s1_d.spc_sign = 1'b0;
        if (cls_p == ClsNan || cls_c == ClsNan) begin
            s1_d.spc = ClsNan;
        end else if (cls_p == ClsInf && cls_c == ClsInf && (prod[15] != addend[15])) begin
            s1_d.spc = ClsNan;
        end else if (cls_p == ClsInf) begin
            s1_d.spc      = ClsInf;
            s1_d.spc_sign = prod[15];
        end else if (cls_c == ClsInf) begin
            s1_d.spc      = ClsInf;
            s1_d.spc_sign = addend[15];
        end else if (cls_p == ClsZero && cls_c == ClsZero) begin
            s1_d.spc      = ClsZero;
            s1_d.spc_sign = prod[15] & addend[15];
        end
    end

    // ---------------- S2: effective add/subtract ----------------
    // |X| >= |Y| so the difference never goes negative
    always_comb begin
        s2_d.sign     = s1_q.sign_x;
        s2_d.exp      = s1_q.exp_x;
        s2_d.spc      = s1_q.spc;
        s2_d.spc_sign = s1_q.spc_sign;
        s2_d.p_ovf    = s1_q.p_ovf;
        s2_d.p_unf    = s1_q.p_unf;
        if (s1_q.sign_x ^ s1_q.sign_y) begin
            s2_d.sum = {1'b0, s1_q.sig_x} - {1'b0, s1_q.sig_y};
        end else begin
            s2_d.sum = {1'b0, s1_q.sig_x} + {1'b0, s1_q.sig_y};
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [3:0]       lzc;
    logic [SIG_W-1:0] norm_m;
    logic [9:0]       e_norm, e_fin;
    logic             g, r, s, round_up;
    logic [8:0]       man_r;
    logic             unused_hidden;

    bf16_lzc u_lzc (
        .din_i (s2_q.sum[SIG_W-1:0]),
        .cnt_o (lzc)
    );

    assign unused_hidden = man_r[7];

    // Normalise, round, then let specials and range checks override the pack
    always_comb begin
        if (s2_q.sum[SIG_W]) begin
            norm_m = {s2_q.sum[11:2], s2_q.sum[1] | s2_q.sum[0]};
            e_norm = {2'b0, s2_q.exp} + 10'd1;
        end else begin
            norm_m = s2_q.sum[SIG_W-1:0] << lzc;
            e_norm = {2'b0, s2_q.exp} - {6'b0, lzc};
        end
        g        = norm_m[2];
        r        = norm_m[1];
        s        = norm_m[0];
        round_up = (RND_MODE == 0) && g && (r || s || norm_m[3]);
        man_r    = {1'b0, norm_m[10:3]} + {8'b0, round_up};
        e_fin    = e_norm + {9'b0, man_r[8]};

        res_d = {s2_q.sign, e_fin[7:0], man_r[8] ? 7'h0 : man_r[6:0]};
        flg_d = {g | r | s, 4'b0000};

        unique case (s2_q.spc)
            ClsNan: begin
                res_d = QNAN;
                flg_d = 5'b01000;
            end
            ClsInf: begin
                res_d = PINF | {s2_q.spc_sign, 15'h0};
                flg_d = 5'b00000;
            end
            ClsZero: begin
                res_d = {s2_q.spc_sign, 15'h0};
                flg_d = 5'b00001;
            end
            ClsNorm: begin
                if (s2_q.sum == '0) begin
                    res_d = 16'h0000;
                    flg_d = 5'b00001;
                end else if (!e_fin[9] && e_fin >= 10'd255) begin
                    res_d = {s2_q.sign, 8'hFF, 7'h0};
                    flg_d = 5'b10010;
                end else if (e_fin[9] || e_fin == 10'd0) begin
                    res_d    = {s2_q.sign, 15'h0};
                    flg_d[2] = 1'b1;
                    flg_d[0] = 1'b1;
                end
            end
        endcase

        flg_d[1] = flg_d[1] | s2_q.p_ovf;
        flg_d[2] = flg_d[2] | s2_q.p_unf;
    end

    // Pipeline registers: all stages shift together on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            res_q       <= '0;
            flg_q       <= '0;
        end else if (advance) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            res_q       <= res_d;
            flg_q       <= flg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign res_inex  = flg_q[4];
    assign res_inv   = flg_q[3];
    assign res_unf   = flg_q[2];
    assign res_ovf   = flg_q[1];
    assign res_zero  = flg_q[0];

`ifdef BF16_ADD_STICKY_FLAGS_EN
    logic [4:0] sticky_q;

    // Accumulate flags of every result actually handed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else if (out_valid_q && out_ready) begin
            sticky_q <= sticky_q | flg_q;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_bf16_fma_add_stage.sv
// Directed self-checking bench for bf16_fma_add_stage.
module tb_bf16_fma_add_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] prod = 16'h0;
    logic        prod_ovf = 1'b0;
    logic        prod_unf = 1'b0;
    logic [15:0] addend = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        res_zero, res_ovf, res_unf, res_inv, res_inex;
    logic [4:0]  flags;
`ifdef BF16_ADD_STICKY_FLAGS_EN
    logic [4:0]  sticky_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign flags = {res_inex, res_inv, res_unf, res_ovf, res_zero};

    bf16_fma_add_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .prod_ovf  (prod_ovf),
        .prod_unf  (prod_unf),
        .addend    (addend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .res_zero  (res_zero),
        .res_ovf   (res_ovf),
        .res_unf   (res_unf),
        .res_inv   (res_inv),
        .res_inex  (res_inex)
`ifdef BF16_ADD_STICKY_FLAGS_EN
        ,
        .sticky_flags (sticky_flags)
`endif
    );

    // One isolated operation with out_ready high; lat counts edges to out_valid
    task automatic run_op(input logic [15:0] p, input logic [15:0] c, input logic po,
                          input logic pu, output logic [15:0] r, output logic [4:0] f,
                          output int lat);
        @(negedge clk);
        prod = p; addend = c; prod_ovf = po; prod_unf = pu;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; prod_ovf = 1'b0; prod_unf = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        f = flags;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (result !== 16'h0 || flags !== 5'b0) begin
            n_fail++; $display("FAIL reset_result: got %h/%b want 0000/00000", result, flags);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] r; logic [4:0] f; int lat;
        run_op(16'h3F80, 16'h3F80, 1'b0, 1'b0, r, f, lat);
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL basic_latency: got %0d edges want 3", lat);
        end
        n_checks++;
        if (r !== 16'h4000 || f !== 5'b00000) begin
            n_fail++; $display("FAIL basic_1p1: got %h/%b want 4000/00000", r, f);
        end
    endtask

    // Directed arithmetic vectors: P, C, expected result, expected {inex,inv,unf,ovf,zero}
    task automatic test_arith();
        logic [15:0] tp [10] = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h4000, 16'h7F80,
                                 16'h7FC1, 16'h7F80, 16'hFF80, 16'h8000, 16'h0081};
        logic [15:0] tc [10] = '{16'hBF80, 16'h3B80, 16'h3C40, 16'hBF80, 16'hFF80,
                                 16'h3F80, 16'h3F80, 16'hFF80, 16'h8000, 16'h8080};
        logic [15:0] tr [10] = '{16'h0000, 16'h3F80, 16'h3F82, 16'h3F80, 16'h7FC0,
                                 16'h7FC0, 16'h7F80, 16'hFF80, 16'h8000, 16'h0000};
        logic [4:0]  tf [10] = '{5'b00001, 5'b10000, 5'b10000, 5'b00000, 5'b01000,
                                 5'b01000, 5'b00000, 5'b00000, 5'b00001, 5'b00101};
        logic [15:0] r; logic [4:0] f; int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(tp[i], tc[i], 1'b0, 1'b0, r, f, lat);
            n_checks++;
            if (r !== tr[i] || f !== tf[i]) begin
                n_fail++;
                $display("FAIL arith_%0d (%h+%h): got %h/%b want %h/%b",
                         i, tp[i], tc[i], r, f, tr[i], tf[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] r; logic [4:0] f; int lat;
        run_op(16'h7F7F, 16'h7F7F, 1'b0, 1'b0, r, f, lat);
        n_checks++;
        if (r !== 16'h7F80 || f !== 5'b10010) begin
            n_fail++; $display("FAIL overflow: got %h/%b want 7F80/10010", r, f);
        end
    endtask

    task automatic test_flag_forward();
        logic [15:0] r; logic [4:0] f; int lat;
        run_op(16'h3F80, 16'h3F80, 1'b1, 1'b0, r, f, lat);
        n_checks++;
        if (r !== 16'h4000 || f !== 5'b00010) begin
            n_fail++; $display("FAIL fwd_prod_ovf: got %h/%b want 4000/00010", r, f);
        end
        run_op(16'h3F80, 16'hBF80, 1'b0, 1'b1, r, f, lat);
        n_checks++;
        if (r !== 16'h0000 || f !== 5'b00101) begin
            n_fail++; $display("FAIL fwd_prod_unf: got %h/%b want 0000/00101", r, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ps [5] = '{16'h3F80, 16'h0000, 16'h3F80, 16'h4000, 16'h3F80};
        logic [15:0] cs [5] = '{16'h3F80, 16'h4000, 16'hBF80, 16'h4000, 16'h0000};
        logic [15:0] ex [5] = '{16'h4000, 16'h4000, 16'h0000, 16'h4080, 16'h3F80};
        logic [15:0] got [$];
        int idx = 0;
        int cyc = 0;
        bit stalled = 0;
        while (got.size() < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = !(cyc >= 2 && cyc <= 5);
            #1;
            if (out_valid && out_ready) got.push_back(result);
            if (idx < 5 && in_ready) begin
                prod = ps[idx]; addend = cs[idx]; in_valid = 1'b1;
                idx++;
            end else begin
                if (idx < 5) stalled = 1;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        n_checks++;
        if (!stalled) begin
            n_fail++; $display("FAIL stream_in_ready_drop: got no stall want in_ready=0");
        end
        n_checks++;
        if (got.size() != 5) begin
            n_fail++; $display("FAIL stream_count: got %0d results want 5", got.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got.size()) begin
                n_fail++; $display("FAIL stream_%0d: got nothing want %h", i, ex[i]);
            end else if (got[i] !== ex[i]) begin
                n_fail++; $display("FAIL stream_%0d: got %h want %h", i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            prod = 16'h3F80; addend = 16'h3F80; in_valid = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got out_valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 16'h0) begin
            n_fail++; $display("FAIL midrst_async: got %b/%h want 0/0000", out_valid, result);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_edge: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL midrst_flush: got %0d stray outputs want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_overflow();
        test_flag_forward();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
